tmr_scrub_ctrl: RTL and testbench
=================================

# tmr_scrub_ctrl

Scrubbing scheduler for a bank of `DEPTH` triplicated self-refreshing registers, each with one majority voter. It shares the bank's single load/address port between three requesters: user writes, error-triggered repairs driven by voter `tmrErr` flags, and a periodic background sweep that rewrites every word with its voted value. It also keeps a saturating count of cycles in which errors were reported. It sits between the configuration/register interface and the TMR register bank.

## Interface
Parameters:
- `DEPTH`, 16 — number of TMR words; valid range is 2 or more.
- `AW`, 4 — address width; must equal clog2(`DEPTH`).
- `PERIOD`, 1024 — idle cycles between sweep starts; valid range is 2 or more.
- `CNT_W`, 16 — width of the error counter.

Ports:
- `clk` in 1 — single clock; all logic is on its rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `scrub_en` in 1 — enables periodic sweeps.
- `wr_req` in 1 — user write request; held high until `wr_ack`.
- `wr_addr` in `AW` — target word of the user write.
- `wr_ack` out 1 — one-cycle acknowledge, coincident with the write's `reg_load`.
- `err_vec` in `DEPTH` — per-word voter error flags (`tmrErr`).
- `reg_load` out 1 — load strobe to the bank.
- `reg_addr` out `AW` — word selected for the load.
- `reg_src` out 1 — 1 selects user data, 0 selects the voted output (refresh).
- `busy` out 1 — high while a sweep is active or any repair is pending.
- `sweep_done` out 1 — one-cycle pulse after the last sweep step.
- `err_count` out `CNT_W` — saturating count of error cycles.
- `err_count_clr` in 1 — synchronous clear of `err_count`.

## Operation
- **Reset values.** All outputs are 0. `pending`, the timer, the sweep pointer and `err_count` are 0. The FSM is in `IDLE`.
- **Pending mask.** `pending[i]` is set at every edge where `err_vec[i]` is 1. It is cleared at the edge where any load to word i is granted. If the set and the clear happen at the same edge, the set wins and the bit stays 1.
- **Per-cycle grant, strict priority (one grant per cycle):**
  - (1) `wr_req`: load `wr_addr` with `reg_src`=1, and pulse `wr_ack`.
  - (2) Any `pending` bit: load the lowest-indexed pending word with `reg_src`=0.
  - (3) FSM in `SWEEP`: load the sweep pointer with `reg_src`=0, then increment the pointer.
  - (4) Nothing granted: `reg_load`=0. `reg_addr` and `reg_src` hold their last values.
- **FSM states:**
  - `IDLE`: the timer increments while `scrub_en`=1. At timer = `PERIOD`-1 the timer resets to 0 and the FSM goes to `SWEEP` with pointer 0. While `scrub_en`=0 the timer is held at 0.
  - `SWEEP`: a sweep step is taken only when neither a write nor a repair is granted; otherwise the pointer holds. When the step for word `DEPTH`-1 is granted, the pointer wraps to 0, the FSM returns to `IDLE`, and `sweep_done` pulses in the next cycle.
  - `scrub_en` falling during `SWEEP` aborts the sweep: the FSM returns to `IDLE`, the pointer and timer go to 0, and `sweep_done` does not pulse.
- **Repairs are independent of `scrub_en`.** They are always serviced.
- **`err_count`:** increments by 1 at each edge where `err_vec` is nonzero, and saturates at 2^`CNT_W`-1. When `err_count_clr` and an increment occur at the same edge, the clear wins and the result is 0.
- **`busy`:** registered. It is 1 in the cycle after any edge that leaves the FSM in `SWEEP` or leaves `pending` nonzero.

## Timing
- All outputs are registered.
- A grant decided at edge k is visible on `reg_load`/`reg_addr`/`reg_src`/`wr_ack` during cycle k to k+1.
- **Write latency.** `wr_req` sampled high at edge k gives `wr_ack` and the load in the cycle after edge k. Keeping `wr_req` high gives back-to-back writes, one per cycle, and starves repairs and sweep steps.
- **Repair latency.** `err_vec[i]` high at edge k sets `pending[i]` at edge k. The repair load is granted at edge k+1, provided no write is requested and no lower-indexed word is pending.
- **Sweep length.** With no contention a sweep spans `DEPTH` consecutive load cycles. The first sweep after reset starts at the `PERIOD`-th edge with `scrub_en`=1.
- **Reset during activity.** `rst` high at an edge overrides everything: the FSM goes to `IDLE`, all outputs and state return to the reset values, and any held `wr_req` is re-evaluated from the first edge after `rst` falls.

## Test plan
- **Sweep.** `DEPTH`=16, `PERIOD`=8, `scrub_en`=1, no other traffic. Required: the first `reg_load` appears in the cycle after edge 8, followed by 16 consecutive loads with addresses 0..15 and `reg_src`=0, then a single `sweep_done` pulse; the next sweep starts 8 cycles later.
- **Write preemption.** Assert `wr_req` with `wr_addr`=5 for 3 cycles mid-sweep at pointer 4. Required: 3 `wr_ack` pulses with `reg_addr`=5 and `reg_src`=1; the sweep then resumes at address 4 and completes with 16 refresh loads in total.
- **Repair ordering.** Pulse `err_vec`=16'h0201 for one cycle with the FSM in `IDLE`. Required: repair loads to word 0 and then word 9 on consecutive cycles, starting 2 cycles after the error edge; `busy`=1 until the cycle after the last repair; `err_count`=1.
- **Set/clear collision.** `err_vec[3]` is high at the same edge a repair of word 3 is granted. Required: `pending[3]` stays 1 and word 3 is repaired a second time.
- **Abort and saturation.** Drop `scrub_en` at pointer 7 mid-sweep. Required: no further sweep loads and no `sweep_done`. Separately, with `CNT_W`=4, hold `err_vec` nonzero for 20 cycles. Required: `err_count`=15; asserting `err_count_clr` together with `err_vec`≠0 gives 0.
- **Reset mid-write.** Assert `rst` while `wr_req` is held. Required: all outputs 0 in the cycle after the reset edge, and `wr_ack` resumes in the cycle after the first edge with `rst`=0.

Source files
------------

// File: rtl/tmr_scrub_ctrl_if.sv
// ----------------------------------------------------------------------------
// tmr_scrub_ctrl_if
//
// Bundles the user write handshake and the TMR bank load port that the
// scrub controller arbitrates.
//
// Signals:
//   wr_req    - user write request, held high until wr_ack
//   wr_addr   - target word of the user write
//   wr_ack    - one-cycle acknowledge, coincident with the write's reg_load
//   reg_load  - load strobe to the TMR bank
//   reg_addr  - word selected for the load
//   reg_src   - 1 = user data, 0 = voted output (refresh)
//
// Modports:
//   master - configuration side: drives requests, observes the bank port
//   slave  - the scrub controller: answers requests, drives the bank port
// ----------------------------------------------------------------------------
interface tmr_scrub_ctrl_if #(
    parameter int unsigned AW = 4
) ();

    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic          wr_ack;
    logic          reg_load;
    logic [AW-1:0] reg_addr;
    logic          reg_src;

    modport master (
        output wr_req,
        output wr_addr,
        input  wr_ack,
        input  reg_load,
        input  reg_addr,
        input  reg_src
    );

    modport slave (
        input  wr_req,
        input  wr_addr,
        output wr_ack,
        output reg_load,
        output reg_addr,
        output reg_src
    );

endinterface

// File: rtl/tmr_scrub_ctrl.sv
// ----------------------------------------------------------------------------
// tmr_scrub_ctrl
//
// Scrubbing scheduler for a bank of DEPTH triplicated registers. Shares the
// bank's single load/address port between three requesters, in strict
// priority order:
//   1. user writes          (reg_src = 1, acknowledged with wr_ack)
//   2. error repairs        (lowest-indexed pending word, reg_src = 0)
//   3. periodic sweep steps (sweep pointer, reg_src = 0)
// One grant per cycle. Every output is registered, so a grant decided at an
// edge is visible for the whole following cycle.
//
// Ports:
//   clk           - clock, rising edge
//   rst           - synchronous active-high reset
//   scrub_en      - enables periodic sweeps; dropping it aborts a sweep
//   err_vec       - per-word voter error flags
//   err_count_clr - synchronous clear of err_count (wins over increment)
//   busy          - sweep active or repair pending (registered)
//   sweep_done    - one-cycle pulse after the last step of a full sweep
//   err_count     - saturating count of cycles with any error flag set
//   bus           - write handshake + bank load port (slave modport)
// ----------------------------------------------------------------------------
module tmr_scrub_ctrl #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4,
    parameter int unsigned PERIOD = 1024,
    parameter int unsigned CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scrub_en,
    input  logic [DEPTH-1:0]   err_vec,
    input  logic               err_count_clr,
    output logic               busy,
    output logic               sweep_done,
    output logic [CNT_W-1:0]   err_count,
    tmr_scrub_ctrl_if.slave    bus
);

    localparam int unsigned TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StSweep = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]       state_q, state_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [DEPTH-1:0] pending_q, pending_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    logic             reg_load_q, reg_load_d;
    logic [AW-1:0]    reg_addr_q, reg_addr_d;
    logic             reg_src_q, reg_src_d;
    logic             wr_ack_q, wr_ack_d;
    logic             busy_q, busy_d;
    logic             sweep_done_q, sweep_done_d;

    // ------------------------------------------------------------------------
    // Grant arbitration
    // ------------------------------------------------------------------------
    logic             any_pending;
    logic [AW-1:0]    rep_addr;
    logic             grant_wr;
    logic             grant_rep;
    logic             grant_swp;
    logic             grant_any;
    logic [AW-1:0]    grant_addr;
    logic [DEPTH-1:0] clr_mask;

    assign any_pending = |pending_q;

    // Lowest-indexed pending word: scan downward so the last hit wins.
    always_comb begin
        rep_addr = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                rep_addr = AW'(i);
            end
        end
    end

    // Repairs use pending as registered, so an error flag seen at an edge
    // is only eligible for repair from the following edge on. A sweep step
    // needs scrub_en too: a low scrub_en in SWEEP is an abort, not a step.
    always_comb begin
        grant_wr  = bus.wr_req;
        grant_rep = !grant_wr && any_pending;
        grant_swp = !grant_wr && !any_pending && (state_q == StSweep) && scrub_en;
        grant_any = grant_wr || grant_rep || grant_swp;

        if (grant_wr) begin
            grant_addr = bus.wr_addr;
        end else if (grant_rep) begin
            grant_addr = rep_addr;
        end else begin
            grant_addr = ptr_q;
        end
    end

    // Any load rewrites the word, whatever its source, so it clears pending.
    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            clr_mask[i] = grant_any && (grant_addr == AW'(i));
        end
    end

    // A fresh error on the same edge as the clear keeps the bit set.
    assign pending_d = (pending_q & ~clr_mask) | err_vec;

    // ------------------------------------------------------------------------
    // Sweep FSM and period timer
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        ptr_d        = ptr_q;
        sweep_done_d = 1'b0;

        case (state_q)
            StIdle: begin
                if (!scrub_en) begin
                    timer_d = '0;
                end else if (timer_q == TW'(PERIOD - 1)) begin
                    timer_d = '0;
                    ptr_d   = '0;
                    state_d = StSweep;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            StSweep: begin
                if (!scrub_en) begin
                    state_d = StIdle;
                    ptr_d   = '0;
                    timer_d = '0;
                end else if (grant_swp) begin
                    if (ptr_q == AW'(DEPTH - 1)) begin
                        ptr_d        = '0;
                        state_d      = StIdle;
                        sweep_done_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = StIdle;
                ptr_d   = '0;
                timer_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Error counter
    // ------------------------------------------------------------------------
    always_comb begin
        err_count_d = err_count_q;
        if (err_count_clr) begin
            err_count_d = '0;
        end else if ((|err_vec) && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    // Address and source hold their last granted values when idle.
    always_comb begin
        reg_load_d = grant_any;
        wr_ack_d   = grant_wr;
        reg_addr_d = grant_any ? grant_addr : reg_addr_q;
        reg_src_d  = grant_any ? grant_wr   : reg_src_q;
        busy_d     = (state_d == StSweep) || (|pending_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            ptr_q        <= '0;
            pending_q    <= '0;
            err_count_q  <= '0;
            reg_load_q   <= 1'b0;
            reg_addr_q   <= '0;
            reg_src_q    <= 1'b0;
            wr_ack_q     <= 1'b0;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            ptr_q        <= ptr_d;
            pending_q    <= pending_d;
            err_count_q  <= err_count_d;
            reg_load_q   <= reg_load_d;
            reg_addr_q   <= reg_addr_d;
            reg_src_q    <= reg_src_d;
            wr_ack_q     <= wr_ack_d;
            busy_q       <= busy_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    assign bus.reg_load = reg_load_q;
    assign bus.reg_addr = reg_addr_q;
    assign bus.reg_src  = reg_src_q;
    assign bus.wr_ack   = wr_ack_q;
    assign busy         = busy_q;
    assign sweep_done   = sweep_done_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_tmr_scrub_ctrl.sv
// ----------------------------------------------------------------------------
// tb_tmr_scrub_ctrl
//
// Directed scenarios followed by random traffic. Every cycle all DUT outputs
// are compared against a behavioural model of the scheduler's rules; the
// directed scenarios add explicit checks on counts and addresses.
// ----------------------------------------------------------------------------
module tb_tmr_scrub_ctrl;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned AW     = 4;
    localparam int unsigned PERIOD = 8;
    localparam int unsigned CNT_W  = 4;
    localparam int          CMAX   = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             scrub_en;
    logic [DEPTH-1:0] err_vec;
    logic             err_count_clr;
    logic             busy;
    logic             sweep_done;
    logic [CNT_W-1:0] err_count;

    tmr_scrub_ctrl_if #(.AW(AW)) bus ();

    tmr_scrub_ctrl #(
        .DEPTH  (DEPTH),
        .AW     (AW),
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .scrub_en      (scrub_en),
        .err_vec       (err_vec),
        .err_count_clr (err_count_clr),
        .busy          (busy),
        .sweep_done    (sweep_done),
        .err_count     (err_count),
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit [DEPTH-1:0] m_pend;
    int             m_timer;
    int             m_ptr;
    bit             m_sweep;
    int             m_cnt;
    bit             e_load, e_src, e_ack, e_busy, e_done;
    int             e_addr;

    // DUT activity counters for the directed scenarios
    int n_ack, n_refresh, n_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock edge of the scheduler's rules, from the inputs as sampled.
    task automatic model_edge();
        int  low;
        int  gaddr;
        bit  g;
        bit  is_wr;
        if (rst) begin
            m_pend = '0; m_timer = 0; m_ptr = 0; m_sweep = 0; m_cnt = 0;
            e_load = 0; e_addr = 0; e_src = 0; e_ack = 0; e_busy = 0; e_done = 0;
            return;
        end
        low = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (low < 0 && m_pend[i]) low = i;
        end
        g = 1; is_wr = 0; gaddr = 0; e_done = 0;
        if (bus.wr_req) begin
            gaddr = int'(bus.wr_addr); is_wr = 1;
        end else if (low >= 0) begin
            gaddr = low;
        end else if (m_sweep && scrub_en) begin
            gaddr = m_ptr;
            if (m_ptr == DEPTH - 1) begin
                m_ptr = 0; m_sweep = 0; e_done = 1;
            end else begin
                m_ptr++;
            end
        end else begin
            g = 0;
        end
        if (m_sweep && !scrub_en) begin
            m_sweep = 0; m_ptr = 0; m_timer = 0;
        end else if (!m_sweep && !e_done) begin
            if (!scrub_en) m_timer = 0;
            else if (m_timer == PERIOD - 1) begin
                m_timer = 0; m_sweep = 1; m_ptr = 0;
            end else m_timer++;
        end
        if (g) m_pend[gaddr] = 1'b0;
        m_pend |= err_vec;
        if (err_count_clr) m_cnt = 0;
        else if (err_vec != 0 && m_cnt < CMAX) m_cnt++;
        e_load = g;
        e_ack  = is_wr;
        if (g) begin
            e_addr = gaddr; e_src = is_wr;
        end
        e_busy = m_sweep || (m_pend != 0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("reg_load",   bus.reg_load, e_load);
        chk("reg_addr",   bus.reg_addr, e_addr);
        chk("reg_src",    bus.reg_src,  e_src);
        chk("wr_ack",     bus.wr_ack,   e_ack);
        chk("busy",       busy,         e_busy);
        chk("sweep_done", sweep_done,   e_done);
        chk("err_count",  err_count,    m_cnt);
        if (bus.wr_ack === 1'b1) n_ack++;
        if (bus.reg_load === 1'b1 && bus.reg_src === 1'b0) n_refresh++;
        if (sweep_done === 1'b1) n_done++;
    endtask

    task automatic clr_counts();
        n_ack = 0; n_refresh = 0; n_done = 0;
    endtask

    initial begin
        int n;
        int first_load;
        rst = 1; scrub_en = 0; err_vec = '0; err_count_clr = 0;
        bus.wr_req = 0; bus.wr_addr = '0;
        step();
        step();
        chk("reset_outputs", {bus.reg_load, bus.wr_ack, busy, sweep_done, bus.reg_src}, 5'b0);
        rst = 0;

        // Sweep: first load in the cycle after edge PERIOD (0-based), 16 loads
        scrub_en = 1; clr_counts();
        first_load = -1;
        for (int e = 0; e < 40 && n_done == 0; e++) begin
            step();
            if (first_load < 0 && bus.reg_load === 1'b1) first_load = e;
        end
        chk("sweep_first_edge", first_load, PERIOD);
        chk("sweep_loads", n_refresh, DEPTH);
        chk("sweep_done_cnt", n_done, 1);

        // Write preemption at pointer 4 of the next sweep
        clr_counts(); n = 0;
        while (n < 60 && !(bus.reg_load === 1'b1 && bus.reg_src === 1'b0 && bus.reg_addr === 4'd3)) begin
            step(); n++;
        end
        chk("reach_ptr4", bus.reg_addr, 3);
        bus.wr_req = 1; bus.wr_addr = 4'd5;
        for (int i = 0; i < 3; i++) step();
        bus.wr_req = 0;
        step();
        chk("resume_addr", bus.reg_addr, 4);
        for (int e = 0; e < 40 && n_done == 0; e++) step();
        chk("preempt_acks", n_ack, 3);
        chk("preempt_loads", n_refresh, DEPTH);
        chk("preempt_done", n_done, 1);

        // Abort at pointer 7
        clr_counts(); n = 0;
        while (n < 60 && !(bus.reg_load === 1'b1 && bus.reg_src === 1'b0 && bus.reg_addr === 4'd6)) begin
            step(); n++;
        end
        chk("reach_ptr7", bus.reg_addr, 6);
        scrub_en = 0;
        for (int i = 0; i < 30; i++) step();
        chk("abort_loads", n_refresh, 7);
        chk("abort_no_done", n_done, 0);

        // Repair ordering with FSM idle
        err_count_clr = 1; step(); err_count_clr = 0;
        err_vec = 16'h0201; step();
        err_vec = '0;
        chk("rep_busy", busy, 1);
        step();
        chk("rep_first", {bus.reg_load, bus.reg_addr}, {1'b1, 4'd0});
        step();
        chk("rep_second", {bus.reg_load, bus.reg_addr}, {1'b1, 4'd9});
        chk("rep_count", err_count, 1);
        step();
        chk("rep_quiet", bus.reg_load, 0);

        // Set/clear collision on word 3
        err_vec = 16'h0008; step();
        step();
        err_vec = '0;
        chk("coll_first", {bus.reg_load, bus.reg_addr}, {1'b1, 4'd3});
        step();
        chk("coll_second", {bus.reg_load, bus.reg_addr}, {1'b1, 4'd3});
        step();
        chk("coll_quiet", bus.reg_load, 0);

        // Saturation and clear priority
        err_vec = 16'h0001;
        for (int i = 0; i < 20; i++) step();
        chk("sat_count", err_count, CMAX);
        err_count_clr = 1; step();
        chk("clr_wins", err_count, 0);
        err_count_clr = 0; err_vec = '0;
        step(); step();

        // Reset during a held write
        bus.wr_req = 1; bus.wr_addr = 4'd9; step();
        rst = 1; step();
        chk("rst_outputs", {bus.reg_load, bus.wr_ack, busy, sweep_done, err_count}, '0);
        rst = 0; step();
        chk("rst_resume", {bus.wr_ack, bus.reg_addr, bus.reg_src}, {1'b1, 4'd9, 1'b1});
        bus.wr_req = 0;

        // Random traffic
        scrub_en = 1;
        for (int i = 0; i < 1500; i++) begin
            rst           = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 49) == 0) scrub_en = ~scrub_en;
            bus.wr_req    = ($urandom_range(0, 5) == 0);
            bus.wr_addr   = AW'($urandom_range(0, DEPTH - 1));
            err_vec       = ($urandom_range(0, 7) == 0) ?
                            (DEPTH'(1) << $urandom_range(0, DEPTH - 1)) |
                            (DEPTH'($urandom_range(0, 1)) << $urandom_range(0, DEPTH - 1)) : '0;
            err_count_clr = ($urandom_range(0, 39) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
